turn_manager: RTL and testbench
===============================

TURN_MANAGER -- requirements
Module: turn_manager

Interface
REQ-001 SHALL have parameter MAX_TURNS, default 20, the turn budget loaded at game start (legal range 1..31).
REQ-002 SHALL have parameter SHIP_CELLS, default 17, the number of hits that wins the game (legal range 1..31).
REQ-003 SHALL have parameter RESP_TIMEOUT, default 1023, the maximum number of cycles to wait for a shot result.
REQ-004 Port: clk  input  1  sole clock; all logic on its rising edge.
REQ-005 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port: start  input  1  single-cycle pulse that begins a new game.
REQ-007 Port: fire  input  1  debounced fire button level; a rising edge requests a shot.
REQ-008 Port: shot_req  output  1  single-cycle pulse asking the board logic to evaluate the cursor cell.
REQ-009 Port: shot_valid  input  1  single-cycle pulse; the result of the outstanding shot is on shot_hit/shot_repeat.
REQ-010 Port: shot_hit  input  1  qualified by shot_valid; the shot hit a ship cell.
REQ-011 Port: shot_repeat  input  1  qualified by shot_valid; the cell was already targeted.
REQ-012 Port: turns_left  output  5  remaining turns; feeds the seven-segment display controller.
REQ-013 Port: hits  output  5  count of distinct ship cells hit.
REQ-014 Port: game_state  output  2  00 IDLE, 01 PLAY, 10 WON, 11 LOST.
REQ-015 Port: timeout_err  output  1  sticky flag; a shot result timed out since the last start.

Function
REQ-016 SHALL use internal FSM states IDLE, ARMED, WAIT_RES, WON and LOST; game_state SHALL report PLAY for both ARMED and WAIT_RES.
REQ-017 In any state, start SHALL load turns_left=MAX_TURNS, hits=0 and timeout_err=0, and enter ARMED on the next cycle; start SHALL take priority over every other input in the same cycle.
REQ-018 SHALL detect fire rising edges with a registered copy of fire; a new game SHALL load that copy with the current fire level, so a button held through start does not fire.
REQ-019 In ARMED, a fire rising edge SHALL assert shot_req for exactly one cycle, on the cycle after the edge, and move the FSM to WAIT_RES.
REQ-020 Fire edges seen outside ARMED SHALL be dropped, not queued.
REQ-021 In WAIT_RES, shot_valid with shot_repeat=1 SHALL return the FSM to ARMED and leave turns_left and hits unchanged; shot_hit SHALL be ignored in this case.
REQ-022 In WAIT_RES, shot_valid with shot_repeat=0 SHALL decrement turns_left by 1, and SHALL increment hits by 1 when shot_hit=1.
REQ-023 After the update in REQ-022, the next state SHALL be chosen from the updated values in this priority order:
  - new hits == SHIP_CELLS -> WON (a win on the last turn counts as WON);
  - else new turns_left == 0 -> LOST;
  - else ARMED.
REQ-024 turns_left SHALL never decrement below 0 and hits SHALL never increment above SHIP_CELLS; no wrap-around is allowed.
REQ-025 SHALL hold a wait counter that clears on entry to WAIT_RES and increments every cycle the FSM stays there.
REQ-026 When the wait counter reaches RESP_TIMEOUT without shot_valid, the FSM SHALL set timeout_err, consume no turn, and return to ARMED.
REQ-027 shot_valid outside WAIT_RES SHALL be ignored.
REQ-028 WON and LOST SHALL hold all outputs steady until start.
REQ-029 All outputs SHALL be driven directly from registers.

Reset
REQ-030 Asserting rst_n low SHALL immediately force: FSM=IDLE, turns_left=MAX_TURNS, hits=0, shot_req=0, timeout_err=0, wait counter=0, registered fire copy=0.
REQ-031 Reset asserted mid-shot (in WAIT_RES) SHALL discard the outstanding shot; a shot_valid arriving after reset releases SHALL be ignored.
REQ-032 Reset release SHALL NOT start a game; only start does.

Structure
REQ-033 SHALL place the state encoding (IDLE/PLAY/WON/LOST codes and internal state codes) in the shared package battleship_pkg, where the VGA renderer also reads them.
REQ-034 SHALL place the MAX_TURNS and SHIP_CELLS defaults in battleship_pkg.
REQ-035 SHALL NOT contain a sub-module; the fire edge detector and the timeout counter are inline logic.

Verification
REQ-036 Reset then start -> turns_left=20, hits=0, game_state=01; hold fire high through start -> no shot_req.
REQ-037 Fire edge, then 3 cycles later shot_valid with hit=1, repeat=0 -> shot_req high for exactly 1 cycle; turns_left=19, hits=1.
REQ-038 shot_valid with repeat=1 -> turns_left and hits unchanged; FSM back in ARMED; a second fire edge produces a new shot_req.
REQ-039 With SHIP_CELLS=2 and MAX_TURNS=2, play hit then hit -> game_state=10 with turns_left=0; then fire edge -> no shot_req.
REQ-040 With RESP_TIMEOUT=8, fire with no response -> timeout_err=1 after 8 wait cycles, turns_left unchanged, FSM in ARMED.
REQ-041 rst_n low while in WAIT_RES, then shot_valid after release -> FSM in IDLE, turns_left=20, hits=0.

Source files
------------

// File: rtl/battleship_pkg.sv
// battleship_pkg: encodings and defaults shared by the turn manager and the
// VGA renderer.
//   CNT_W          width of the turn and hit counters
//   *_DEF          default game parameters
//   game_state_e   externally visible game phase (IDLE/PLAY/WON/LOST)
//   tm_state_e     internal turn-manager FSM states
package battleship_pkg;

    localparam int unsigned CNT_W            = 5;
    localparam int unsigned MAX_TURNS_DEF    = 20;
    localparam int unsigned SHIP_CELLS_DEF   = 17;
    localparam int unsigned RESP_TIMEOUT_DEF = 1023;

    typedef enum logic [1:0] {
        GS_IDLE = 2'b00,
        GS_PLAY = 2'b01,
        GS_WON  = 2'b10,
        GS_LOST = 2'b11
    } game_state_e;

    typedef enum logic [2:0] {
        TM_IDLE     = 3'd0,
        TM_ARMED    = 3'd1,
        TM_WAIT_RES = 3'd2,
        TM_WON      = 3'd3,
        TM_LOST     = 3'd4
    } tm_state_e;

endpackage

// File: rtl/turn_manager_if.sv
// turn_manager_if: player controls, shot handshake with the board logic and
// game status toward the display.
//   start, fire                          player controls
//   shot_req / shot_valid, shot_hit,
//   shot_repeat                          shot request and its result
//   turns_left, hits, game_state,
//   timeout_err                          game status
// modport master: the turn manager; modport slave: the board/player side.
interface turn_manager_if;
    import battleship_pkg::*;

    logic              start;
    logic              fire;
    logic              shot_req;
    logic              shot_valid;
    logic              shot_hit;
    logic              shot_repeat;
    logic [CNT_W-1:0]  turns_left;
    logic [CNT_W-1:0]  hits;
    game_state_e       game_state;
    logic              timeout_err;

    modport master (
        input  start, fire, shot_valid, shot_hit, shot_repeat,
        output shot_req, turns_left, hits, game_state, timeout_err
    );

    modport slave (
        output start, fire, shot_valid, shot_hit, shot_repeat,
        input  shot_req, turns_left, hits, game_state, timeout_err
    );

endinterface

// File: rtl/turn_manager.sv
// turn_manager: battleship turn sequencing. Turns fire-button edges into shot
// requests, applies shot results to the turn and hit counters, times out a
// board that never answers, and decides win/loss.
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          turn_manager_if.master (controls, shot handshake, status)
module turn_manager
    import battleship_pkg::*;
#(
    parameter int unsigned MAX_TURNS    = MAX_TURNS_DEF,
    parameter int unsigned SHIP_CELLS   = SHIP_CELLS_DEF,
    parameter int unsigned RESP_TIMEOUT = RESP_TIMEOUT_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    turn_manager_if.master bus
);

    // Counter only needs to reach RESP_TIMEOUT-1: the timeout fires on that cycle.
    localparam int unsigned WAIT_W = (RESP_TIMEOUT < 2) ? 1 : $clog2(RESP_TIMEOUT);

    tm_state_e         state;
    game_state_e       gs_q;
    logic [CNT_W-1:0]  turns_q;
    logic [CNT_W-1:0]  hits_q;
    logic              req_q;
    logic              terr_q;
    logic              fire_q;
    logic [WAIT_W-1:0] wait_cnt;

    logic              fire_rise_c;
    logic              turn_dec_c;
    logic              hit_inc_c;
    logic [CNT_W-1:0]  turns_nxt_c;
    logic [CNT_W-1:0]  hits_nxt_c;

    // Edge detect and saturating counter updates for a non-repeat result.
    always_comb begin
        fire_rise_c = bus.fire & ~fire_q;
        turn_dec_c  = (turns_q != '0);
        hit_inc_c   = bus.shot_hit && (hits_q != CNT_W'(SHIP_CELLS));
        turns_nxt_c = turns_q - CNT_W'(turn_dec_c);
        hits_nxt_c  = hits_q + CNT_W'(hit_inc_c);
    end

    // Game FSM with registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= TM_IDLE;
            gs_q     <= GS_IDLE;
            turns_q  <= CNT_W'(MAX_TURNS);
            hits_q   <= '0;
            req_q    <= 1'b0;
            terr_q   <= 1'b0;
            fire_q   <= 1'b0;
            wait_cnt <= '0;
        end else begin
            // Also the start-time load: a button held through start is not an edge.
            fire_q <= bus.fire;
            req_q  <= 1'b0;
            if (bus.start) begin
                state    <= TM_ARMED;
                gs_q     <= GS_PLAY;
                turns_q  <= CNT_W'(MAX_TURNS);
                hits_q   <= '0;
                terr_q   <= 1'b0;
                wait_cnt <= '0;
            end else begin
                case (state)
                    TM_ARMED: begin
                        if (fire_rise_c) begin
                            req_q    <= 1'b1;
                            wait_cnt <= '0;
                            state    <= TM_WAIT_RES;
                        end
                    end
                    TM_WAIT_RES: begin
                        if (bus.shot_valid) begin
                            if (bus.shot_repeat) begin
                                state <= TM_ARMED;
                            end else begin
                                turns_q <= turns_nxt_c;
                                hits_q  <= hits_nxt_c;
                                // Win is checked first so a hit on the last turn wins.
                                if (hits_nxt_c == CNT_W'(SHIP_CELLS)) begin
                                    state <= TM_WON;
                                    gs_q  <= GS_WON;
                                end else if (turns_nxt_c == '0) begin
                                    state <= TM_LOST;
                                    gs_q  <= GS_LOST;
                                end else begin
                                    state <= TM_ARMED;
                                end
                            end
                        end else if (wait_cnt == WAIT_W'(RESP_TIMEOUT - 1)) begin
                            terr_q <= 1'b1;
                            state  <= TM_ARMED;
                        end else begin
                            wait_cnt <= wait_cnt + WAIT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.shot_req    = req_q;
    assign bus.turns_left  = turns_q;
    assign bus.hits        = hits_q;
    assign bus.game_state  = gs_q;
    assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_turn_manager.sv
// tb_turn_manager: drives two turn_manager instances (20 turns / 17 cells and
// 2 turns / 2 cells, both with an 8-cycle response timeout) with identical
// directed and random stimulus and compares every output each cycle against
// a behavioural game model.
module tb_turn_manager;
    import battleship_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    turn_manager_if bus_a();
    turn_manager_if bus_b();

    turn_manager #(.MAX_TURNS(20), .SHIP_CELLS(17), .RESP_TIMEOUT(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );
    turn_manager #(.MAX_TURNS(2), .SHIP_CELLS(2), .RESP_TIMEOUT(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Game model parameters per instance.
    int P_MAX  [2] = '{20, 2};
    int P_SHIP [2] = '{17, 2};
    int P_TO   [2] = '{8, 8};

    // Game model: whether a game is running, whether a shot is outstanding and
    // for how long, the counters, and the last seen fire level.
    bit m_in_game [2];
    bit m_wait_on [2];
    int m_waited  [2];
    int m_turns   [2];
    int m_hits    [2];
    bit m_terr    [2];
    bit m_req     [2];
    bit m_pf      [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset(input int i);
        m_in_game[i] = 1'b0;
        m_wait_on[i] = 1'b0;
        m_waited[i]  = 0;
        m_turns[i]   = P_MAX[i];
        m_hits[i]    = 0;
        m_terr[i]    = 1'b0;
        m_req[i]     = 1'b0;
        m_pf[i]      = 1'b0;
    endtask

    function automatic int m_gs(input int i);
        if (!m_in_game[i])                return 0;
        else if (m_hits[i] == P_SHIP[i])  return 2;
        else if (m_turns[i] == 0)         return 3;
        else                              return 1;
    endfunction

    task automatic model_step(input int i, input bit st, input bit fr,
                              input bit sv, input bit sh, input bit sr);
        bit over;
        if (!rst_n) begin
            model_reset(i);
        end else begin
            over = m_in_game[i] && (m_hits[i] == P_SHIP[i] || m_turns[i] == 0);
            m_req[i] = 1'b0;
            if (st) begin
                m_in_game[i] = 1'b1;
                m_wait_on[i] = 1'b0;
                m_turns[i]   = P_MAX[i];
                m_hits[i]    = 0;
                m_terr[i]    = 1'b0;
            end else if (m_in_game[i] && !over && !m_wait_on[i]) begin
                if (fr && !m_pf[i]) begin
                    m_req[i]     = 1'b1;
                    m_wait_on[i] = 1'b1;
                    m_waited[i]  = 0;
                end
            end else if (m_wait_on[i]) begin
                if (sv) begin
                    m_wait_on[i] = 1'b0;
                    if (!sr) begin
                        if (m_turns[i] > 0) m_turns[i]--;
                        if (sh && m_hits[i] < P_SHIP[i]) m_hits[i]++;
                    end
                end else if (m_waited[i] + 1 == P_TO[i]) begin
                    m_terr[i]    = 1'b1;
                    m_wait_on[i] = 1'b0;
                end else begin
                    m_waited[i]++;
                end
            end
            m_pf[i] = fr;
        end
    endtask

    task automatic check_all();
        chk("a.req",   bus_a.shot_req,    m_req[0]);
        chk("a.turns", bus_a.turns_left,  m_turns[0]);
        chk("a.hits",  bus_a.hits,        m_hits[0]);
        chk("a.state", bus_a.game_state,  m_gs(0));
        chk("a.terr",  bus_a.timeout_err, m_terr[0]);
        chk("b.req",   bus_b.shot_req,    m_req[1]);
        chk("b.turns", bus_b.turns_left,  m_turns[1]);
        chk("b.hits",  bus_b.hits,        m_hits[1]);
        chk("b.state", bus_b.game_state,  m_gs(1));
        chk("b.terr",  bus_b.timeout_err, m_terr[1]);
    endtask

    // One clock: drive on the falling edge, update model at the rising edge,
    // compare 1 time unit later.
    task automatic cycle(input bit rst, input bit st, input bit fr,
                         input bit sv, input bit sh, input bit sr);
        @(negedge clk);
        rst_n = rst;
        bus_a.start = st; bus_a.fire = fr; bus_a.shot_valid = sv;
        bus_a.shot_hit = sh; bus_a.shot_repeat = sr;
        bus_b.start = st; bus_b.fire = fr; bus_b.shot_valid = sv;
        bus_b.shot_hit = sh; bus_b.shot_repeat = sr;
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_step(i, st, fr, sv, sh, sr);
        #1;
        check_all();
    endtask

    initial begin
        bit fr, st, sv, sh, sr, rs;
        for (int i = 0; i < 2; i++) model_reset(i);
        bus_a.start = 0; bus_a.fire = 0; bus_a.shot_valid = 0; bus_a.shot_hit = 0; bus_a.shot_repeat = 0;
        bus_b.start = 0; bus_b.fire = 0; bus_b.shot_valid = 0; bus_b.shot_hit = 0; bus_b.shot_repeat = 0;

        // Reset values, then release without start stays idle.
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        chk("rst.state",   bus_a.game_state, 0);
        chk("rst.turns_a", bus_a.turns_left, 20);
        chk("rst.turns_b", bus_b.turns_left, 2);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 1, 0, 0, 0);
        cycle(1, 0, 1, 0, 0, 0);
        chk("norun.state", bus_a.game_state, 0);
        chk("norun.req",   bus_a.shot_req, 0);

        // Start with fire held high: no shot.
        cycle(1, 1, 1, 0, 0, 0);
        chk("start.turns", bus_a.turns_left, 20);
        chk("start.hits",  bus_a.hits, 0);
        chk("start.state", bus_a.game_state, 1);
        cycle(1, 0, 1, 0, 0, 0);
        chk("held.req", bus_a.shot_req, 0);
        cycle(1, 0, 1, 0, 0, 0);
        chk("held.req2", bus_a.shot_req, 0);
        cycle(1, 0, 0, 0, 0, 0);

        // Fire edge, result hit three cycles later.
        cycle(1, 0, 1, 0, 0, 0);
        chk("shot.req1", bus_a.shot_req, 1);
        cycle(1, 0, 1, 0, 0, 0);
        chk("shot.req0", bus_a.shot_req, 0);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 1, 1, 0);
        chk("hit.turns", bus_a.turns_left, 19);
        chk("hit.hits",  bus_a.hits, 1);

        // Repeat result leaves counters alone and re-arms.
        cycle(1, 0, 1, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 1, 1, 1);
        chk("rep.turns", bus_a.turns_left, 19);
        chk("rep.hits",  bus_a.hits, 1);
        chk("rep.state", bus_a.game_state, 1);
        cycle(1, 0, 1, 0, 0, 0);
        chk("rep.req", bus_a.shot_req, 1);
        cycle(1, 0, 0, 0, 0, 0);

        // Second hit wins the small game on its last turn.
        cycle(1, 0, 0, 1, 1, 0);
        chk("win.state", bus_b.game_state, 2);
        chk("win.turns", bus_b.turns_left, 0);
        chk("win.hits",  bus_b.hits, 2);
        cycle(1, 0, 1, 0, 0, 0);
        chk("won.req",  bus_b.shot_req, 0);
        chk("a.req3",   bus_a.shot_req, 1);

        // No response: timeout after 8 waiting cycles, no turn consumed.
        for (int k = 0; k < 7; k++) cycle(1, 0, 0, 0, 0, 0);
        chk("to.early", bus_a.timeout_err, 0);
        cycle(1, 0, 0, 0, 0, 0);
        chk("to.err",   bus_a.timeout_err, 1);
        chk("to.turns", bus_a.turns_left, 18);
        chk("to.state", bus_a.game_state, 1);
        cycle(1, 0, 1, 0, 0, 0);
        chk("to.rearm", bus_a.shot_req, 1);

        // Asynchronous reset while a shot is outstanding; late result ignored.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst.state", bus_a.game_state, 0);
        chk("arst.turns", bus_a.turns_left, 20);
        for (int i = 0; i < 2; i++) model_reset(i);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 1, 1, 0);
        chk("late.state", bus_a.game_state, 0);
        chk("late.turns", bus_a.turns_left, 20);
        chk("late.hits",  bus_a.hits, 0);

        // Random play.
        fr = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            rs = ($urandom_range(0, 499) != 0);
            st = (n == 0) || ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 3) == 0) fr = ~fr;
            sv = ($urandom_range(0, 3) == 0);
            sh = 1'($urandom);
            sr = ($urandom_range(0, 4) == 0);
            cycle(rs, st, fr, sv, sh, sr);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
